// File: rtl/lru_pkg.sv
// Shared types and constants for the 4-way LRU age controller.
package lru_pkg;
  localparam int AGE_W    = 2;
  localparam int NUM_WAYS = 4;

  localparam logic [AGE_W-1:0] AGE_MRU = 2'b11;
  localparam logic [AGE_W-1:0] AGE_LRU = 2'b00;

  localparam logic [NUM_WAYS*AGE_W-1:0] INIT_AGES =
    {2'd3, 2'd2, 2'd1, 2'd0};

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_e;
endpackage

// File: rtl/lru_age_update.sv
// Combinational age update for one set: picks the target way
// and promotes it to MRU, aging the ways that were above it.
import lru_pkg::*;

module lru_age_update (
  input  logic [7:0] ages,
  input  logic       hit,
  input  logic [1:0] way,
  output logic [7:0] new_ages,
  output logic [1:0] tgt_way
);

  logic [1:0]       w_tgt;
  logic [AGE_W-1:0] w_r;
  logic [AGE_W-1:0] w_age;

  always_comb begin
    w_tgt = way;
    if (!hit) begin
      w_tgt = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (ages[2*w +: AGE_W] == AGE_LRU)
          w_tgt = 2'(w);
      end
    end
  end

  assign w_r     = ages[{w_tgt, 1'b0} +: AGE_W];
  assign tgt_way = w_tgt;

  always_comb begin
    new_ages = ages;
    w_age    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_age = ages[2*w +: AGE_W];
      if (2'(w) == w_tgt)
        new_ages[2*w +: AGE_W] = AGE_MRU;
      else if (w_age > w_r)
        new_ages[2*w +: AGE_W] = w_age - 2'd1;
    end
  end

endmodule

// File: rtl/lru_set_controller.sv
// Per-set LRU age store with a two-stage access pipeline
// and a drain-then-sweep flush sequencer.
import lru_pkg::*;

module lru_set_controller #(
  parameter int NUM_SETS = 16,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [SET_W-1:0] acc_set,
  input  logic             acc_hit,
  input  logic [1:0]       acc_way,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             rsp_valid,
  output logic [SET_W-1:0] rsp_set,
  output logic             rsp_hit,
  output logic [1:0]       rsp_way,
  output logic [7:0]       rsp_ages
);

  state_e           r_state;
  state_e           w_next;
  logic [SET_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;

  logic             r_a_valid;
  logic [SET_W-1:0] r_a_set;
  logic             r_a_hit;
  logic [1:0]       r_a_way;

  logic [7:0]       r_ages [NUM_SETS];
  logic [7:0]       w_cur_ages;
  logic [7:0]       w_new_ages;
  logic [1:0]       w_tgt_way;

  assign w_accept   = acc_valid && acc_ready;
  assign w_last     = (r_cnt == SET_W'(NUM_SETS - 1));
  assign w_cur_ages = r_ages[r_a_set];

  always_comb begin
    w_next     = r_state;
    acc_ready  = 1'b0;
    flush_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        acc_ready = !flush_req;
        if (flush_req) w_next = DRAIN;
      end
      DRAIN: if (!r_a_valid) w_next = FLUSH;
      FLUSH: if (w_last) w_next = DONE;
      DONE: begin
        flush_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FLUSH) r_cnt <= r_cnt + 1'b1;
      else                  r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_set   <= '0;
      r_a_hit   <= 1'b0;
      r_a_way   <= '0;
    end else begin
      r_a_valid <= w_accept;
      if (w_accept) begin
        r_a_set <= acc_set;
        r_a_hit <= acc_hit;
        r_a_way <= acc_way;
      end
    end
  end

  lru_age_update u_upd (
    .ages     (w_cur_ages),
    .hit      (r_a_hit),
    .way      (r_a_way),
    .new_ages (w_new_ages),
    .tgt_way  (w_tgt_way)
  );

  // Flush and stage-B writes never overlap: FLUSH is only entered once A is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        r_ages[s] <= INIT_AGES;
    end else if (r_state == FLUSH) begin
      r_ages[r_cnt] <= INIT_AGES;
    end else if (r_a_valid) begin
      r_ages[r_a_set] <= w_new_ages;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_set   <= '0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_ages  <= '0;
    end else begin
      rsp_valid <= r_a_valid;
      if (r_a_valid) begin
        rsp_set  <= r_a_set;
        rsp_hit  <= r_a_hit;
        rsp_way  <= w_tgt_way;
        rsp_ages <= w_new_ages;
      end
    end
  end

endmodule
